boa_branch_predictor: RTL and testbench

BOA_BRANCH_PREDICTOR -- requirements
Module: boa_branch_predictor

---
 rtl/boa_branch_predictor.sv | 136 +++++++++++++
 tb/tb_boa_branch_predictor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boa_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from stored state; updates, flush and reset land on the rising edge.
module boa_branch_predictor #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned TAG_BITS = 8,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lk_valid,
    input  logic [31:1] lk_pc,
    output logic        lk_hit,
    output logic        lk_taken,
    output logic [31:1] lk_target,
    input  logic        up_valid,
    input  logic [31:1] up_pc,
    input  logic        up_taken,
    input  logic        up_jump,
    input  logic [31:1] up_target,
    input  logic        flush,
    output logic [31:0] perf_lookups,
    output logic [31:0] perf_hits
);

    localparam int unsigned IDX    = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX + 1;
    localparam int unsigned TAG_HI = IDX + TAG_BITS;

    localparam logic [1:0] CTR_SN = 2'b00;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    typedef struct packed {
        logic [TAG_BITS-1:0] tag;
        logic [31:1]         target;
        logic [1:0]          ctr;
    } entry_t;

    // Payload storage is unreset; the valid vector alone gates visibility.
    entry_t             entry_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q;

    logic [IDX-1:0]      lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    entry_t              lk_ent;

    logic [IDX-1:0]      up_idx;
    logic [TAG_BITS-1:0] up_tag;
    entry_t              up_ent;
    entry_t              up_ent_d;
    logic                up_hit;
    logic                up_we;

    // PC bits above the tag field do not participate in indexing or matching.
    logic unused_pc_hi;
    assign unused_pc_hi = ^{lk_pc[31:TAG_HI+1], up_pc[31:TAG_HI+1]};

    assign lk_idx = lk_pc[IDX:1];
    assign lk_tag = lk_pc[TAG_HI:TAG_LO];
    assign lk_ent = entry_q[lk_idx];

    assign up_idx = up_pc[IDX:1];
    assign up_tag = up_pc[TAG_HI:TAG_LO];
    assign up_ent = entry_q[up_idx];

    // Lookup path: reads pre-edge state, so a same-index update is not forwarded.
    always_comb begin
        lk_hit    = 1'b0;
        lk_taken  = 1'b0;
        lk_target = '0;
        if (lk_valid && valid_q[lk_idx] && (lk_ent.tag == lk_tag)) begin
            lk_hit    = 1'b1;
            lk_taken  = lk_ent.ctr[1];
            lk_target = lk_ent.target;
        end
    end

    assign up_hit = valid_q[up_idx] && (up_ent.tag == up_tag);
    assign up_we  = up_valid && !flush && !rst;

    // Next entry contents: allocate on miss, train counter/target on hit.
    always_comb begin
        up_ent_d = up_ent;
        if (!up_hit) begin
            up_ent_d.tag    = up_tag;
            up_ent_d.target = up_target;
            if (up_jump) begin
                up_ent_d.ctr = CTR_ST;
            end else if (up_taken) begin
                up_ent_d.ctr = CTR_WT;
            end else begin
                up_ent_d.ctr = CTR_INIT;
            end
        end else begin
            if (up_jump) begin
                up_ent_d.ctr = CTR_ST;
            end else if (up_taken) begin
                up_ent_d.ctr = (up_ent.ctr == CTR_ST) ? CTR_ST : up_ent.ctr + 2'd1;
            end else begin
                up_ent_d.ctr = (up_ent.ctr == CTR_SN) ? CTR_SN : up_ent.ctr - 2'd1;
            end
            if (up_taken) begin
                up_ent_d.target = up_target;
            end
        end
    end

    // Valid bits: reset beats flush, flush beats update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (up_valid) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (up_we) begin
            entry_q[up_idx] <= up_ent_d;
        end
    end

    // Performance counters survive flush and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lookups <= '0;
            perf_hits    <= '0;
        end else begin
            perf_lookups <= perf_lookups + 32'(lk_valid);
            perf_hits    <= perf_hits + 32'(lk_hit);
        end
    end

endmodule

// File: tb/tb_boa_branch_predictor.sv
// Bench for boa_branch_predictor: directed vectors with literal expectations plus an
// array-based reference model compared against the DUT every cycle.
module tb_boa_branch_predictor;

    localparam int unsigned ENTRIES  = 16;
    localparam int unsigned TAG_BITS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        lk_valid;
    logic [31:1] lk_pc;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:1] lk_target;
    logic        up_valid;
    logic [31:1] up_pc;
    logic        up_taken;
    logic        up_jump;
    logic [31:1] up_target;
    logic        flush;
    logic [31:0] perf_lookups;
    logic [31:0] perf_hits;

    always #5 clk = ~clk;

    boa_branch_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CTR_INIT(2'b01)) dut (
        .clk(clk), .rst(rst),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
        .lk_target(lk_target),
        .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_jump(up_jump),
        .up_target(up_target), .flush(flush),
        .perf_lookups(perf_lookups), .perf_hits(perf_hits)
    );

    // Reference model: byte addresses, counter as an integer strength 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int unsigned m_pl, m_ph;
    bit          model_ok = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Literal expectations handed from the driver to the compare process.
    int          lk_seq = 0, pf_seq = 0;
    string       lit_name, pf_name;
    bit          lit_hit, lit_taken;
    logic [31:0] lit_tgt;
    int unsigned pf_l, pf_h;

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return (a / (2 * ENTRIES)) % (1 << TAG_BITS);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks mid-cycle, then advances the model at the edge.
    initial begin : compare
        int          lk_seen = 0, pf_seen = 0;
        logic [31:0] a, ua;
        int unsigned i, j;
        bit          e_hit, e_tk, hu;
        logic [31:0] e_tg;
        bit          c_rst, c_fl, c_lkv, c_upv, c_tk, c_jp, c_hit;
        logic [31:0] c_upa, c_tg;
        forever begin
            @(negedge clk);
            #2;
            a     = {lk_pc, 1'b0};
            i     = idx_of(a);
            e_hit = lk_valid && m_valid[i] && (m_tag[i] == tag_of(a));
            e_tk  = e_hit && (m_ctr[i] >= 2);
            e_tg  = e_hit ? m_tgt[i] : 32'h0;
            if (model_ok) begin
                check("model lk_hit", 32'(lk_hit), 32'(e_hit));
                check("model lk_taken", 32'(lk_taken), 32'(e_tk));
                check("model lk_target", {lk_target, 1'b0}, {e_tg[31:1], 1'b0});
                check("model perf_lookups", perf_lookups, m_pl);
                check("model perf_hits", perf_hits, m_ph);
            end
            if (lk_seq != lk_seen) begin
                lk_seen = lk_seq;
                check({lit_name, " hit"}, 32'(lk_hit), 32'(lit_hit));
                check({lit_name, " taken"}, 32'(lk_taken), 32'(lit_taken));
                check({lit_name, " target"}, {lk_target, 1'b0}, lit_tgt);
            end
            if (pf_seq != pf_seen) begin
                pf_seen = pf_seq;
                check({pf_name, " perf_lookups"}, perf_lookups, pf_l);
                check({pf_name, " perf_hits"}, perf_hits, pf_h);
            end
            c_rst = rst; c_fl = flush; c_lkv = lk_valid; c_upv = up_valid;
            c_tk = up_taken; c_jp = up_jump; c_upa = {up_pc, 1'b0};
            c_tg = {up_target, 1'b0}; c_hit = e_hit;
            @(posedge clk);
            if (c_rst) begin
                foreach (m_valid[k]) m_valid[k] = 1'b0;
                m_pl = 0;
                m_ph = 0;
                model_ok = 1'b1;
            end else begin
                if (c_lkv) m_pl++;
                if (c_hit) m_ph++;
                if (c_fl) begin
                    foreach (m_valid[k]) m_valid[k] = 1'b0;
                end else if (c_upv) begin
                    ua = c_upa;
                    j  = idx_of(ua);
                    hu = m_valid[j] && (m_tag[j] == tag_of(ua));
                    if (!hu) begin
                        m_valid[j] = 1'b1;
                        m_tag[j]   = tag_of(ua);
                        m_tgt[j]   = c_tg;
                        m_ctr[j]   = c_jp ? 3 : (c_tk ? 2 : 1);
                    end else begin
                        if (c_jp)      m_ctr[j] = 3;
                        else if (c_tk) m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
                        else           m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
                        if (c_tk) m_tgt[j] = c_tg;
                    end
                end
            end
        end
    end

    task automatic cyc(input bit r, input bit fl, input bit lkv, input logic [31:0] lka,
                       input bit upv, input logic [31:0] upa, input bit tk, input bit jp,
                       input logic [31:0] tg);
        @(negedge clk);
        rst = r; flush = fl;
        lk_valid = lkv; lk_pc = lka[31:1];
        up_valid = upv; up_pc = upa[31:1]; up_taken = tk; up_jump = jp; up_target = tg[31:1];
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic look(input logic [31:0] a);
        cyc(0, 0, 1, a, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic upd(input logic [31:0] a, input bit tk, input bit jp, input logic [31:0] tg);
        cyc(0, 0, 0, 32'h0, 1, a, tk, jp, tg);
    endtask

    task automatic exp_lk(input string n, input bit h, input bit t, input logic [31:0] tg);
        lit_name = n; lit_hit = h; lit_taken = t; lit_tgt = tg; lk_seq++;
    endtask

    task automatic exp_pf(input string n, input int unsigned l, input int unsigned h);
        pf_name = n; pf_l = l; pf_h = h; pf_seq++;
    endtask

    initial begin : driver
        logic [31:0] pool [5];
        pool[0] = 32'h4000_0010; pool[1] = 32'h4000_0210; pool[2] = 32'h4000_0020;
        pool[3] = 32'h4000_003e; pool[4] = 32'h8000_1010;
        rst = 1'b1; flush = 1'b0; lk_valid = 1'b0; lk_pc = '0;
        up_valid = 1'b0; up_pc = '0; up_taken = 1'b0; up_jump = 1'b0; up_target = '0;

        // Reset with an update pending: the update must be dropped.
        cyc(1, 0, 1, 32'h4000_0010, 1, 32'h4000_0010, 1, 0, 32'h4000_0100);
        cyc(1, 0, 1, 32'h4000_0010, 1, 32'h4000_0010, 1, 0, 32'h4000_0100);
        idle();                         exp_lk("post-reset idle", 0, 0, 32'h0);
                                        exp_pf("post-reset", 0, 0);
        look(32'h4000_0010);            exp_lk("cold lookup", 0, 0, 32'h0);
        idle();                         exp_pf("cold lookup", 1, 0);

        // Allocate taken, then predict.
        upd(32'h4000_0010, 1, 0, 32'h4000_0100);
        look(32'h4000_0010);            exp_lk("alloc predict", 1, 1, 32'h4000_0100);

        // Counter walks down and saturates; not-taken never moves the target.
        upd(32'h4000_0010, 0, 0, 32'h5000_0000);
        look(32'h4000_0010);            exp_lk("ctr 01", 1, 0, 32'h4000_0100);
        upd(32'h4000_0010, 0, 0, 32'h5000_0000);
        upd(32'h4000_0010, 0, 0, 32'h5000_0000);
        look(32'h4000_0010);            exp_lk("ctr 00 sat", 1, 0, 32'h4000_0100);
        upd(32'h4000_0010, 1, 0, 32'h4000_0200);
        look(32'h4000_0010);            exp_lk("ctr 00->01", 1, 0, 32'h4000_0200);

        // Alias at index 8 with a different tag.
        look(32'h4000_0210);            exp_lk("alias miss", 0, 0, 32'h0);
        upd(32'h4000_0210, 1, 1, 32'h4000_0800);
        look(32'h4000_0010);            exp_lk("replaced miss", 0, 0, 32'h0);
        look(32'h4000_0210);            exp_lk("jump alloc", 1, 1, 32'h4000_0800);

        // Same-index lookup and replacing update in one cycle sees the old entry.
        cyc(0, 0, 1, 32'h4000_0210, 1, 32'h4000_0010, 1, 0, 32'h4000_1234);
                                        exp_lk("same-cycle old", 1, 1, 32'h4000_0800);
        look(32'h4000_0210);            exp_lk("same-cycle after", 0, 0, 32'h0);
        look(32'h4000_0010);            exp_lk("same-cycle new", 1, 1, 32'h4000_1234);

        // Index boundaries 0 and 15; not-taken allocation uses the init counter.
        upd(32'h4000_0020, 0, 0, 32'h4000_0400);
        look(32'h4000_0020);            exp_lk("idx0 init", 1, 0, 32'h4000_0400);
        upd(32'h4000_003e, 1, 1, 32'h4000_0600);
        look(32'h4000_003e);            exp_lk("idx15 jump", 1, 1, 32'h4000_0600);
        upd(32'h4000_0020, 1, 0, 32'h4000_0404);
        look(32'h4000_0020);            exp_lk("idx0 taken", 1, 1, 32'h4000_0404);

        // Flush wins over a same-cycle update.
        cyc(0, 1, 1, 32'h4000_0020, 1, 32'h4000_0040, 1, 0, 32'h4000_0900);
                                        exp_lk("flush cycle", 1, 1, 32'h4000_0404);
        look(32'h4000_0040);            exp_lk("flush drop upd", 0, 0, 32'h0);
        look(32'h4000_0020);            exp_lk("flush idx0", 0, 0, 32'h0);
        look(32'h4000_003e);            exp_lk("flush idx15", 0, 0, 32'h0);
        look(32'h4000_0010);            exp_lk("flush idx8", 0, 0, 32'h0);

        // Reset mid-run with an update pending and counters nonzero.
        upd(32'h4000_0010, 1, 0, 32'h4000_0100);
        look(32'h4000_0010);            exp_lk("pre-reset hit", 1, 1, 32'h4000_0100);
        cyc(1, 0, 1, 32'h4000_0010, 1, 32'h4000_0020, 1, 1, 32'h4000_0700);
        look(32'h4000_0010);            exp_lk("post-reset miss", 0, 0, 32'h0);
                                        exp_pf("mid-run reset", 0, 0);
        look(32'h4000_0020);            exp_lk("reset drop upd", 0, 0, 32'h0);
        idle();                         exp_pf("after reset looks", 2, 0);

        // Mixed traffic over a small aliasing address pool, checked by the model.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                1'($urandom_range(0, 1)), pool[$urandom_range(0, 4)],
                1'($urandom_range(0, 1)), pool[$urandom_range(0, 4)],
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                $urandom() & 32'hffff_fffe);
        end
        idle();
        idle();
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
